// File: rtl/trace_line_checker.sv
// trace_line_checker: character-serial parser and checker for simulator trace lines.
// Grammar: '^' dec '@' hex ':' sp* ( '$' dec sp* | '*' hex sp* ) '<' '=' sp* hex '#'
// A well-formed line produces a one-cycle result (format_type/error_code) in DONE.
// Valid/ready: there is no handshake; char is consumed every cycle and the result
// is qualified only by format_type != 0, which holds for exactly one cycle.
module trace_line_checker #(
    parameter int          DEC_MAX    = 4,
    parameter int          HEX_DIGITS = 8,
    parameter int          FREQ_W     = 16,
    parameter logic [31:0] PC_LO      = 32'h0000_3000,
    parameter logic [31:0] PC_HI      = 32'h0000_4fff,
    parameter logic [31:0] ADDR_HI    = 32'h0000_2fff,
    parameter int          GRF_NUM    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        char,
    input  logic [FREQ_W-1:0] freq,
    output logic [1:0]        format_type,
    output logic [3:0]        error_code,
    output logic [15:0]       line_count,
    output logic [3:0]        state_dbg
);

    localparam int HEX_W = 4 * HEX_DIGITS;
    localparam int MOD_W = (FREQ_W > 32) ? FREQ_W : 32;
    localparam int REG_W = 16;

    localparam logic [HEX_W-1:0] PC_LO_H   = HEX_W'(PC_LO);
    localparam logic [HEX_W-1:0] PC_HI_H   = HEX_W'(PC_HI);
    localparam logic [HEX_W-1:0] ADDR_HI_H = HEX_W'(ADDR_HI);
    localparam logic [REG_W-1:0] GRF_LIM   = REG_W'(GRF_NUM);
    localparam logic [7:0]       DEC_LIM   = 8'(DEC_MAX);
    localparam logic [7:0]       HEX_LIM   = 8'(HEX_DIGITS);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_TIME    = 4'd1;
    localparam logic [3:0] S_PC      = 4'd2;
    localparam logic [3:0] S_COLON   = 4'd3;
    localparam logic [3:0] S_SEP     = 4'd4;
    localparam logic [3:0] S_REG     = 4'd5;
    localparam logic [3:0] S_ADDR    = 4'd6;
    localparam logic [3:0] S_PRE_LT  = 4'd7;
    localparam logic [3:0] S_EQ      = 4'd8;
    localparam logic [3:0] S_DATA_SP = 4'd9;
    localparam logic [3:0] S_DATA    = 4'd10;
    localparam logic [3:0] S_HASH    = 4'd11;
    localparam logic [3:0] S_DONE    = 4'd12;

    localparam logic [7:0] C_CARET = 8'h5e;
    localparam logic [7:0] C_AT    = 8'h40;
    localparam logic [7:0] C_COLON = 8'h3a;
    localparam logic [7:0] C_SP    = 8'h20;
    localparam logic [7:0] C_DOLL  = 8'h24;
    localparam logic [7:0] C_STAR  = 8'h2a;
    localparam logic [7:0] C_LT    = 8'h3c;
    localparam logic [7:0] C_EQ    = 8'h3d;
    localparam logic [7:0] C_HASH  = 8'h23;

    logic [3:0]       state, state_nxt;
    logic [7:0]       cnt;
    logic [MOD_W-1:0] time_acc;
    logic [HEX_W-1:0] pc_acc;
    logic [HEX_W-1:0] addr_acc;
    logic [REG_W-1:0] reg_acc;
    logic             is_mem;
    logic [1:0]       fmt_q;
    logic [3:0]       err_q;

    logic             is_dec, is_hex;
    logic [3:0]       nibble;
    logic [REG_W+3:0] reg_mul;
    logic [FREQ_W-1:0] half_freq;
    logic [3:0]       err_nxt;

    // Character classification: lower-case hex only, 'a' maps to 10.
    always_comb begin
        is_dec = (char >= 8'h30) && (char <= 8'h39);
        is_hex = is_dec || ((char >= 8'h61) && (char <= 8'h66));
        nibble = is_dec ? char[3:0] : (char[3:0] + 4'd9);
    end

    // Next-state logic; '^' restarts from any state, anything unexpected drops to IDLE.
    always_comb begin
        state_nxt = S_IDLE;
        if (char == C_CARET) begin
            state_nxt = S_TIME;
        end else begin
            case (state)
                S_TIME:    if (is_dec) state_nxt = (cnt == DEC_LIM) ? S_IDLE : S_TIME;
                           else if (char == C_AT && cnt != 8'd0) state_nxt = S_PC;
                S_PC:      if (is_hex) state_nxt = (cnt == HEX_LIM) ? S_IDLE : S_PC;
                           else if (char == C_COLON && cnt == HEX_LIM) state_nxt = S_COLON;
                S_COLON,
                S_SEP:     if (char == C_SP) state_nxt = S_SEP;
                           else if (char == C_DOLL) state_nxt = S_REG;
                           else if (char == C_STAR) state_nxt = S_ADDR;
                S_REG:     if (is_dec) state_nxt = (cnt == DEC_LIM) ? S_IDLE : S_REG;
                           else if (cnt != 8'd0 && char == C_SP) state_nxt = S_PRE_LT;
                           else if (cnt != 8'd0 && char == C_LT) state_nxt = S_EQ;
                S_ADDR:    if (is_hex) state_nxt = (cnt == HEX_LIM) ? S_IDLE : S_ADDR;
                           else if (cnt == HEX_LIM && char == C_SP) state_nxt = S_PRE_LT;
                           else if (cnt == HEX_LIM && char == C_LT) state_nxt = S_EQ;
                S_PRE_LT:  if (char == C_SP) state_nxt = S_PRE_LT;
                           else if (char == C_LT) state_nxt = S_EQ;
                S_EQ:      if (char == C_EQ) state_nxt = S_DATA_SP;
                S_DATA_SP: if (char == C_SP) state_nxt = S_DATA_SP;
                           else if (is_hex) state_nxt = (HEX_LIM == 8'd1) ? S_HASH : S_DATA;
                S_DATA:    if (is_hex) state_nxt = (cnt == HEX_LIM - 8'd1) ? S_HASH : S_DATA;
                S_HASH:    if (char == C_HASH) state_nxt = S_DONE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Error flags evaluated from the accumulators and the freq value seen with '#'.
    always_comb begin
        half_freq  = freq >> 1;
        reg_mul    = ({4'd0, reg_acc} * 20'd10) + {{(REG_W){1'b0}}, nibble};
        err_nxt    = 4'd0;
        if (half_freq != '0)
            err_nxt[0] = (time_acc % MOD_W'(half_freq)) != '0;
        err_nxt[1] = (pc_acc < PC_LO_H) || (pc_acc > PC_HI_H) || (pc_acc[1:0] != 2'b00);
        err_nxt[2] = is_mem && ((addr_acc > ADDR_HI_H) || (addr_acc[1:0] != 2'b00));
        err_nxt[3] = !is_mem && (reg_acc >= GRF_LIM);
    end

    // State, field accumulators, digit counter, result latch and line counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            time_acc   <= '0;
            pc_acc     <= '0;
            addr_acc   <= '0;
            reg_acc    <= '0;
            is_mem     <= 1'b0;
            fmt_q      <= 2'b00;
            err_q      <= 4'd0;
            line_count <= 16'd0;
        end else begin
            state <= state_nxt;
            if (char == C_CARET) begin
                cnt      <= 8'd0;
                time_acc <= '0;
                pc_acc   <= '0;
                addr_acc <= '0;
                reg_acc  <= '0;
                is_mem   <= 1'b0;
            end else begin
                if (state_nxt != state)
                    cnt <= (state_nxt == S_DATA) ? 8'd1 : 8'd0;
                else if (is_hex)
                    cnt <= cnt + 8'd1;
                case (state)
                    S_TIME:  if (is_dec) time_acc <= (time_acc * MOD_W'(10)) + MOD_W'(nibble);
                    S_PC:    if (is_hex) pc_acc <= {pc_acc[HEX_W-5:0], nibble};
                    S_ADDR:  if (is_hex) addr_acc <= {addr_acc[HEX_W-5:0], nibble};
                    S_REG:   if (is_dec) reg_acc <= (reg_mul > {4'd0, {REG_W{1'b1}}}) ?
                                                    {REG_W{1'b1}} : reg_mul[REG_W-1:0];
                    S_COLON,
                    S_SEP:   if (char == C_STAR) is_mem <= 1'b1;
                             else if (char == C_DOLL) is_mem <= 1'b0;
                    default: ;
                endcase
            end
            if (state == S_HASH && state_nxt == S_DONE) begin
                fmt_q      <= is_mem ? 2'b10 : 2'b01;
                err_q      <= err_nxt;
                line_count <= line_count + 16'd1;
            end
        end
    end

    assign format_type = (state == S_DONE) ? fmt_q : 2'b00;
    assign error_code  = (state == S_DONE) ? err_q : 4'd0;
    assign state_dbg   = state;

endmodule
